// File: rtl/ram_mem_ws.sv
// ============================================================================
// Module  : ram_mem_ws
// Purpose : Byte-addressed little-endian RAM with programmable wait states,
//           per-byte write enables and an access-error flag.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_mem_ws #(
  parameter logic [31:0] START_ADDRESS = 32'h0000_0000,
  parameter int          MEMORY_SIZE   = 2048,
  parameter int          DATA_WIDTH    = 32,
  parameter int          WAIT_STATES   = 2,
  parameter string       INIT_FILE     = ""
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      req,
  input  logic                      we,
  input  logic [DATA_WIDTH/8-1:0]   be,
  input  logic [31:0]               address,
  input  logic [DATA_WIDTH-1:0]     wdata,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic                      hold,
  output logic                      ack,
  output logic                      err
);

  localparam int          NB    = DATA_WIDTH / 8;
  localparam int          AW    = $clog2(MEMORY_SIZE);
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);
  localparam logic [31:0] MAX_OFF = 32'(MEMORY_SIZE - NB);
  localparam logic [31:0] ALIGN_MASK = 32'(NB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    run_q;
  logic                    we_q;
  logic [NB-1:0]           be_q;
  logic [31:0]             addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic [7:0]              mem_q [MEMORY_SIZE];

  logic                    accept;
  logic                    acc_we;
  logic [NB-1:0]           acc_be;
  logic [31:0]             acc_addr;
  logic [DATA_WIDTH-1:0]   acc_wdata;
  logic [31:0]             acc_off;
  logic [AW-1:0]           acc_idx;
  logic                    acc_valid;
  logic                    do_write;

  // run_q keeps requests from being taken on the first edge after reset,
  // so a request present while reset is asserted can never touch storage.
  assign accept = req && run_q && (state_q != S_WAIT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (accept) begin
          cnt_d   = WS;
          state_d = (WS == 4'd0) ? S_RESP : S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // With zero wait states the access edge is the accept edge itself, so the
  // live inputs are used instead of the latched copy.
  always_comb begin
    acc_we    = (state_q == S_WAIT) ? we_q    : we;
    acc_be    = (state_q == S_WAIT) ? be_q    : be;
    acc_addr  = (state_q == S_WAIT) ? addr_q  : address;
    acc_wdata = (state_q == S_WAIT) ? wdata_q : wdata;
    acc_off   = acc_addr - START_ADDRESS;
    acc_idx   = acc_off[AW-1:0];
    acc_valid = (acc_off <= MAX_OFF) && ((acc_off & ALIGN_MASK) == 32'd0);
  end

  always_comb begin
    rdata_d  = '0;
    err_d    = 1'b0;
    do_write = 1'b0;
    if (state_d == S_RESP) begin
      if (!acc_valid) begin
        err_d = 1'b1;
      end else if (acc_we) begin
        do_write = 1'b1;
      end else begin
        for (int i = 0; i < NB; i++) begin
          rdata_d[8*i +: 8] = mem_q[acc_idx + AW'(i)];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= 1'b1;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q    <= we;
        be_q    <= be;
        addr_q  <= address;
        wdata_q <= wdata;
      end
    end
  end

  // Storage has no reset; do_write is only possible while run_q is set.
  always_ff @(posedge clock) begin
    if (do_write) begin
      for (int i = 0; i < NB; i++) begin
        if (acc_be[i]) mem_q[acc_idx + AW'(i)] <= acc_wdata[8*i +: 8];
      end
    end
  end

  assign hold  = (state_q == S_WAIT);
  assign ack   = (state_q == S_RESP);
  assign rdata = rdata_q;
  assign err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_mem_ws.sv
// ============================================================================
// Module  : tb_ram_mem_ws
// Purpose : Directed, table-driven checks of ram_mem_ws in three configurations.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ram_mem_ws;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic        req_a, we_a, hold_a, ack_a, err_a;
  logic [3:0]  be_a;
  logic [31:0] addr_a, wd_a, rd_a;

  logic        req_b, we_b, hold_b, ack_b, err_b;
  logic [3:0]  be_b;
  logic [31:0] addr_b, wd_b, rd_b;

  logic        req_c, we_c, hold_c, ack_c, err_c;
  logic [7:0]  be_c;
  logic [31:0] addr_c;
  logic [63:0] wd_c, rd_c;

  ram_mem_ws #(.START_ADDRESS(32'h0), .MEMORY_SIZE(2048), .DATA_WIDTH(32), .WAIT_STATES(2), .INIT_FILE("")) u_a (
    .clock(clk), .reset_n(reset_n), .req(req_a), .we(we_a), .be(be_a), .address(addr_a),
    .wdata(wd_a), .rdata(rd_a), .hold(hold_a), .ack(ack_a), .err(err_a));

  ram_mem_ws #(.START_ADDRESS(32'h0), .MEMORY_SIZE(2048), .DATA_WIDTH(32), .WAIT_STATES(0), .INIT_FILE("")) u_b (
    .clock(clk), .reset_n(reset_n), .req(req_b), .we(we_b), .be(be_b), .address(addr_b),
    .wdata(wd_b), .rdata(rd_b), .hold(hold_b), .ack(ack_b), .err(err_b));

  ram_mem_ws #(.START_ADDRESS(32'h0), .MEMORY_SIZE(2048), .DATA_WIDTH(64), .WAIT_STATES(5), .INIT_FILE("")) u_c (
    .clock(clk), .reset_n(reset_n), .req(req_c), .we(we_c), .be(be_c), .address(addr_c),
    .wdata(wd_c), .rdata(rd_c), .hold(hold_c), .ack(ack_c), .err(err_c));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic hold_b_seen = 1'b0;
  always @(negedge clk) if (hold_b === 1'b1) hold_b_seen = 1'b1;

  // Called just after a falling edge; returns just after the falling edge
  // on which ack is seen (lat counts falling edges after the accept edge).
  task automatic access(input int d, input logic w, input logic [7:0] b, input logic [31:0] a,
                        input logic [63:0] wd, output logic [63:0] rd, output logic e,
                        output int lat, output int hc);
    logic h, k;
    logic [63:0] r;
    logic ee;
    case (d)
      0: begin req_a = 1'b1; we_a = w; be_a = b[3:0]; addr_a = a; wd_a = wd[31:0]; end
      1: begin req_b = 1'b1; we_b = w; be_b = b[3:0]; addr_b = a; wd_b = wd[31:0]; end
      default: begin req_c = 1'b1; we_c = w; be_c = b; addr_c = a; wd_c = wd; end
    endcase
    @(posedge clk);
    #1;
    case (d)
      0: req_a = 1'b0;
      1: req_b = 1'b0;
      default: req_c = 1'b0;
    endcase
    lat = 0; hc = 0; rd = '0; e = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      lat++;
      case (d)
        0: begin h = hold_a; k = ack_a; r = {32'h0, rd_a}; ee = err_a; end
        1: begin h = hold_b; k = ack_b; r = {32'h0, rd_b}; ee = err_b; end
        default: begin h = hold_c; k = ack_c; r = rd_c; ee = err_c; end
      endcase
      if (h === 1'b1) hc++;
      if (k === 1'b1) begin
        rd = r; e = ee;
        break;
      end
    end
  endtask

  typedef struct {
    logic        w;
    logic [3:0]  b;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] erd;
    logic        ee;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl [NV];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] rd;
    logic        e;
    int          lat, hc, acks;
    logic [31:0] bv [4];

    //            w     be     addr          wdata         exp rdata     err
    tbl[0]  = '{1'b1, 4'hF, 32'h0000_0010, 32'hDEADBEEF, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 4'hF, 32'h0000_0010, 32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 4'hF, 32'h0000_0020, 32'h11223344, 32'h0,        1'b0};
    tbl[3]  = '{1'b1, 4'h5, 32'h0000_0020, 32'hAABBCCDD, 32'h0,        1'b0};
    tbl[4]  = '{1'b0, 4'h0, 32'h0000_0020, 32'h0,        32'h11BB33DD, 1'b0};
    tbl[5]  = '{1'b0, 4'hF, 32'h0000_07FE, 32'h0,        32'h0,        1'b1};
    tbl[6]  = '{1'b0, 4'hF, 32'h0000_0022, 32'h0,        32'h0,        1'b1};
    tbl[7]  = '{1'b0, 4'hF, 32'hFFFF_FFFC, 32'h0,        32'h0,        1'b1};
    tbl[8]  = '{1'b1, 4'hF, 32'h0000_07FC, 32'h55667788, 32'h0,        1'b0};
    tbl[9]  = '{1'b0, 4'hF, 32'h0000_07FC, 32'h0,        32'h55667788, 1'b0};
    tbl[10] = '{1'b1, 4'hF, 32'h0000_0800, 32'h99999999, 32'h0,        1'b1};
    tbl[11] = '{1'b1, 4'h0, 32'h0000_0020, 32'hFFFFFFFF, 32'h0,        1'b0};
    tbl[12] = '{1'b0, 4'hF, 32'h0000_0020, 32'h0,        32'h11BB33DD, 1'b0};
    tbl[13] = '{1'b0, 4'hF, 32'h0000_0010, 32'h0,        32'hDEADBEEF, 1'b0};
    tbl[14] = '{1'b1, 4'hF, 32'h0000_0040, 32'h01020304, 32'h0,        1'b0};

    bv[0] = 32'h0000_1111; bv[1] = 32'h2222_3333; bv[2] = 32'h4444_5555; bv[3] = 32'h6666_7777;

    reset_n = 1'b0;
    req_a = 0; we_a = 0; be_a = 0; addr_a = 0; wd_a = 0;
    req_b = 0; we_b = 0; be_b = 0; addr_b = 0; wd_b = 0;
    req_c = 0; we_c = 0; be_c = 0; addr_c = 0; wd_c = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_outs", {hold_a, ack_a, err_a, rd_a}, 64'h0);
    chk("rst_b_outs", {hold_b, ack_b, err_b, rd_b}, 64'h0);
    chk("rst_c_hold_ack_err", {hold_c, ack_c, err_c}, 64'h0);
    chk("rst_c_rdata", rd_c, 64'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Table: WS=2, 32-bit. Every access shows 2 hold cycles and ack 3 cycles after accept.
    for (int i = 0; i < NV; i++) begin
      access(0, tbl[i].w, {4'h0, tbl[i].b}, tbl[i].a, {32'h0, tbl[i].wd}, rd, e, lat, hc);
      chk($sformatf("a_vec%0d_rdata", i), rd, {32'h0, tbl[i].erd});
      chk($sformatf("a_vec%0d_err", i), {63'h0, e}, {63'h0, tbl[i].ee});
      chk($sformatf("a_vec%0d_latency", i), 64'(lat), 64'd3);
      chk($sformatf("a_vec%0d_hold_cycles", i), 64'(hc), 64'd2);
    end
    chk("a_byte_0x10_lane0", {56'h0, tbl[1].erd[7:0]}, 64'hEF);
    @(negedge clk);
    chk("a_ack_drops_after_one", {hold_a, ack_a, err_a, rd_a}, 64'h0);

    // WS=0: preload four words, then stream four reads with req held high.
    for (int k = 0; k < 4; k++) begin
      access(1, 1'b1, 8'h0F, 32'(4 * k), {32'h0, bv[k]}, rd, e, lat, hc);
      chk($sformatf("b_wr%0d_latency", k), 64'(lat), 64'd1);
    end
    req_b = 1'b1; we_b = 1'b0; be_b = 4'hF; addr_b = 32'h0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (k < 3) addr_b = 32'(4 * (k + 1));
      else req_b = 1'b0;
      @(negedge clk);
      chk($sformatf("b_stream%0d_ack", k), {63'h0, ack_b}, 64'h1);
      chk($sformatf("b_stream%0d_rdata", k), {32'h0, rd_b}, {32'h0, bv[k]});
      chk($sformatf("b_stream%0d_err", k), {63'h0, err_b}, 64'h0);
    end
    @(negedge clk);
    chk("b_ack_after_stream", {62'h0, ack_b, err_b}, 64'h0);
    chk("b_hold_never", {63'h0, hold_b_seen}, 64'h0);

    // Asynchronous reset in the middle of a WAIT for a write to 0x40.
    req_a = 1'b1; we_a = 1'b1; be_a = 4'hF; addr_a = 32'h40; wd_a = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    req_a = 1'b0;
    @(negedge clk);
    chk("rst5_hold_before", {63'h0, hold_a}, 64'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst5_outs_drop", {hold_a, ack_a, err_a, rd_a}, 64'h0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    acks = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (ack_a === 1'b1) acks++;
    end
    chk("rst5_no_ack_after", 64'(acks), 64'd0);
    access(0, 1'b0, 8'h0F, 32'h40, 64'h0, rd, e, lat, hc);
    chk("rst5_0x40_unchanged", rd, 64'h0000_0000_0102_0304);

    // WS=5, 64-bit.
    access(2, 1'b1, 8'hFF, 32'h8, 64'h0123_4567_89AB_CDEF, rd, e, lat, hc);
    chk("c_wr_latency", 64'(lat), 64'd6);
    chk("c_wr_hold_cycles", 64'(hc), 64'd5);
    chk("c_wr_err", {63'h0, e}, 64'h0);
    access(2, 1'b0, 8'hFF, 32'h8, 64'h0, rd, e, lat, hc);
    chk("c_rd_latency", 64'(lat), 64'd6);
    chk("c_rd_data", rd, 64'h0123_4567_89AB_CDEF);
    access(2, 1'b1, 8'h0F, 32'h8, 64'hFFFF_FFFF_FFFF_FFFF, rd, e, lat, hc);
    access(2, 1'b0, 8'hFF, 32'h8, 64'h0, rd, e, lat, hc);
    chk("c_partial_rd", rd, 64'h0123_4567_FFFF_FFFF);
    access(2, 1'b0, 8'hFF, 32'h4, 64'h0, rd, e, lat, hc);
    chk("c_misaligned_err", {63'h0, e}, 64'h1);
    chk("c_misaligned_rdata", rd, 64'h0);
    access(2, 1'b1, 8'hFF, 32'h7F8, 64'hA5A5_5A5A_0F0F_F0F0, rd, e, lat, hc);
    chk("c_top_wr_err", {63'h0, e}, 64'h0);
    access(2, 1'b0, 8'hFF, 32'h7F8, 64'h0, rd, e, lat, hc);
    chk("c_top_rd", rd, 64'hA5A5_5A5A_0F0F_F0F0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
